// File: rtl/micro_ucr_nonce_search_if.sv
// micro_ucr_nonce_search_if: request/response link between the nonce search controller and the hash core
interface micro_ucr_nonce_search_if;
    logic         hash_init;
    logic         valid;
    logic [127:0] block_in;
    logic [23:0]  hash;
    logic         hash_ready;
    modport master (output hash_init, valid, block_in, input hash, hash_ready);
    modport slave  (input hash_init, valid, block_in, output hash, hash_ready);
endinterface

// File: rtl/micro_ucr_nonce_search.sv
// micro_ucr_nonce_search: proof-of-work nonce search driving micro_ucr_hash until a hit, exhaustion, timeout or stop
module micro_ucr_nonce_search #(
    parameter int NONCE_W = 32,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic [95:0]        payload,
    input  logic [7:0]         target,
    micro_ucr_nonce_search_if.master core,
    output logic               busy,
    output logic               found,
    output logic               exhausted,
    output logic               timeout_err,
    output logic [NONCE_W-1:0] nonce,
    output logic [23:0]        golden_hash
);
    typedef enum logic [2:0] {IDLE, ARM, ISSUE, LOAD, WAIT, CHECK, DONE} state_t;
    state_t state, state_n;
    logic [95:0]        payload_q, payload_n;
    logic [7:0]         target_q, target_n, wd, wd_n;
    logic [23:0]        last_hash, last_hash_n, golden_n;
    logic [NONCE_W-1:0] nonce_n;
    logic [127:0]       block_n;
    logic               found_n, exhausted_n, timeout_n, busy_n, init_n, valid_n, hit;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            payload_q      <= '0;
            target_q       <= '0;
            wd             <= '0;
            last_hash      <= '0;
            golden_hash    <= '0;
            nonce          <= '0;
            found          <= 1'b0;
            exhausted      <= 1'b0;
            timeout_err    <= 1'b0;
            busy           <= 1'b0;
            core.hash_init <= 1'b0;
            core.valid     <= 1'b0;
            core.block_in  <= '0;
        end else begin
            state          <= state_n;
            payload_q      <= payload_n;
            target_q       <= target_n;
            wd             <= wd_n;
            last_hash      <= last_hash_n;
            golden_hash    <= golden_n;
            nonce          <= nonce_n;
            found          <= found_n;
            exhausted      <= exhausted_n;
            timeout_err    <= timeout_n;
            busy           <= busy_n;
            core.hash_init <= init_n;
            core.valid     <= valid_n;
            core.block_in  <= block_n;
        end
    end
    always_comb begin
        hit         = (last_hash[23:16] < target_q) && (last_hash[15:8] < target_q);
        state_n     = state;
        payload_n   = payload_q;
        target_n    = target_q;
        wd_n        = wd;
        last_hash_n = last_hash;
        golden_n    = golden_hash;
        nonce_n     = nonce;
        found_n     = found;
        exhausted_n = exhausted;
        timeout_n   = timeout_err;
        init_n      = 1'b0;
        valid_n     = 1'b0;
        block_n     = core.block_in;
        if (stop && busy) begin
            state_n = DONE;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state_n     = ARM;
                    payload_n   = payload;
                    target_n    = target;
                    nonce_n     = '0;
                    found_n     = 1'b0;
                    exhausted_n = 1'b0;
                    timeout_n   = 1'b0;
                    golden_n    = '0;
                end
                // a still-high hash_ready belongs to an earlier request, so hold off issuing
                ARM: if (!core.hash_ready) begin
                    state_n = ISSUE;
                    init_n  = 1'b1;
                    valid_n = 1'b1;
                    block_n = {32'(nonce), payload_q};
                end
                ISSUE: begin
                    state_n = LOAD;
                    valid_n = 1'b1;
                end
                LOAD: begin
                    state_n = WAIT;
                    wd_n    = '0;
                end
                WAIT: if (core.hash_ready) begin
                    state_n     = CHECK;
                    last_hash_n = core.hash;
                end else if (wd == 8'(TIMEOUT - 1)) begin
                    state_n   = DONE;
                    timeout_n = 1'b1;
                end else begin
                    wd_n = wd + 8'd1;
                end
                CHECK: if (hit) begin
                    state_n  = DONE;
                    found_n  = 1'b1;
                    golden_n = last_hash;
                end else if (nonce == '1) begin
                    state_n     = DONE;
                    exhausted_n = 1'b1;
                end else begin
                    state_n = ARM;
                    nonce_n = nonce + NONCE_W'(1);
                end
                DONE: state_n = start ? DONE : IDLE;
                default: state_n = IDLE;
            endcase
        end
        busy_n = state_n inside {ARM, ISSUE, LOAD, WAIT, CHECK};
    end
endmodule

// File: tb/tb_micro_ucr_nonce_search.sv
// tb_micro_ucr_nonce_search: directed bench with a stub hash core answering 5 cycles after each request
module tb_micro_ucr_nonce_search;
    localparam logic [95:0] P = 96'h0102030405060708090A0B0C;
    logic clk = 1'b0, reset = 1'b0, start = 1'b0, stop = 1'b0;
    logic [95:0] payload = P;
    logic [7:0]  target = 8'h10;
    logic busy, found, exhausted, timeout_err;
    logic [3:0]  nonce;
    logic [23:0] golden_hash;
    logic stub_en = 1'b1, hold = 1'b0, stub_ready = 1'b0;
    logic [23:0] stub_hash = '0;
    logic [31:0] hit_nonce = 32'd3, req_nonce = '0;
    int cnt = 0, pulses = 0, p0, n, vectors = 0, errs = 0;

    micro_ucr_nonce_search_if bus ();
    assign bus.hash_ready = stub_ready | hold;
    assign bus.hash = stub_hash;

    micro_ucr_nonce_search #(.NONCE_W(4), .TIMEOUT(20)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .payload(payload), .target(target),
        .core(bus.master), .busy(busy), .found(found), .exhausted(exhausted),
        .timeout_err(timeout_err), .nonce(nonce), .golden_hash(golden_hash));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.hash_init) begin
            pulses    <= pulses + 1;
            cnt       <= 5;
            req_nonce <= bus.block_in[127:96];
        end else if (cnt > 1) begin
            cnt <= cnt - 1;
        end else if (cnt == 1) begin
            cnt <= 0;
            if (stub_en) begin
                stub_ready <= 1'b1;
                stub_hash  <= (req_nonce == hit_nonce) ? 24'h0A0B00 : 24'hFFFFFF;
            end
        end else if (stub_ready) begin
            stub_ready <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic go(input bit keep);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = keep;
    endtask

    task automatic wait_idle();
        n = 0;
        while (busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("search_ends", busy, 0);
    endtask

    task automatic wait_wait();
        n = 0;
        while (!bus.valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("issue_seen", bus.valid, 1);
        while (bus.valid && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_flags", {found, exhausted, timeout_err}, 0);
        chk("rst_nonce", nonce, 0);
        chk("rst_golden", golden_hash, 0);
        chk("rst_bus", {bus.hash_init, bus.valid, bus.block_in}, 0);
        reset = 1'b1;

        p0 = pulses;
        go(0);
        chk("busy_after_start", busy, 1);
        wait_idle();
        chk("hit_pulses", pulses - p0, 4);
        chk("hit_found", found, 1);
        chk("hit_nonce", nonce, 3);
        chk("hit_golden", golden_hash, 24'h0A0B00);
        chk("hit_other_flags", {exhausted, timeout_err}, 0);
        chk("hit_block_in", bus.block_in, {32'd3, P});

        hit_nonce = 32'hFFFF_FFFF;
        p0 = pulses;
        go(0);
        wait_idle();
        chk("exh_pulses", pulses - p0, 16);
        chk("exh_flag", exhausted, 1);
        chk("exh_nonce", nonce, 4'hF);
        chk("exh_found", found, 0);
        chk("exh_golden", golden_hash, 0);

        hit_nonce = 32'd15;
        go(0);
        wait_idle();
        chk("last_hit_flags", {found, exhausted}, 2'b10);
        chk("last_hit_nonce", nonce, 4'hF);

        stub_en = 1'b0;
        go(0);
        wait_wait();
        n = 0;
        while (!timeout_err && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("to_latency", n, 20);
        chk("to_busy_valid", {busy, bus.valid}, 0);
        chk("to_other_flags", {found, exhausted}, 0);
        stub_en = 1'b1;

        payload = 96'hA5A5_0000_1111_2222_3333_4444;
        go(0);
        payload = P;
        wait_wait();
        reset = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_bus", {bus.hash_init, bus.valid, bus.block_in}, 0);
        chk("arst_nonce_flags", {nonce, found, exhausted, timeout_err}, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("arst_stays_idle", busy, 0);

        hit_nonce = 32'd0;
        hold = 1'b1;
        p0 = pulses;
        go(0);
        repeat (8) @(negedge clk);
        chk("guard_no_pulse", pulses - p0, 0);
        chk("guard_busy", busy, 1);
        hold = 1'b0;
        @(negedge clk);
        chk("guard_issue", {bus.hash_init, bus.valid}, 2'b11);
        chk("guard_block", bus.block_in, {32'd0, P});
        @(negedge clk);
        chk("guard_load", {bus.hash_init, bus.valid}, 2'b01);
        wait_idle();
        chk("guard_found", {found, nonce}, {1'b1, 4'd0});

        hit_nonce = 32'd5;
        go(1);
        wait_wait();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("stop_busy", busy, 0);
        chk("stop_flags", {found, exhausted, timeout_err}, 0);
        chk("stop_bus", {bus.hash_init, bus.valid}, 0);
        repeat (3) @(negedge clk);
        chk("stop_done_hold", busy, 0);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("rearm_busy", busy, 1);
        wait_idle();
        chk("rearm_result", {found, nonce, golden_hash}, {1'b1, 4'd5, 24'h0A0B00});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
